// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
// Sequencer for a serial chain of scan flops. Paces the chain with one-cycle
// cp enable pulses, drives te/ti, samples the chain's serial output and runs
// load, optional capture, and unload sequences. All outputs are registered.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int DIV       = 4
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 capture,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 so_in,
  output logic                 cp_out,
  output logic                 te_out,
  output logic                 ti_out,
  output logic                 sd_n_out,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] unload_data
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [CHAIN_LEN-1:0] ld_q, ld_d;
  logic                 cap_q, cap_d;
  logic                 cp_q, cp_d;
  logic                 te_q, te_d;
  logic                 ti_q, ti_d;
  logic                 sd_n_q;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] unload_q, unload_d;

  assign cp_out      = cp_q;
  assign te_out      = te_q;
  assign ti_out      = ti_q;
  assign sd_n_out    = sd_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign unload_data = unload_q;

  // Next-state logic: cp_q marks the pulse cycle, so every shift, sample and
  // state change happens on the edge that closes a cp pulse.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    ld_d     = ld_q;
    cap_d    = cap_q;
    te_d     = te_q;
    ti_d     = ti_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unload_d = unload_q;
    cp_d     = 1'b0;

    if (abort) begin
      state_d = IDLE;
      div_d   = '0;
      bit_d   = '0;
      te_d    = 1'b0;
      ti_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SHIFT_IN;
            ld_d    = load_data << 1;
            cap_d   = capture;
            busy_d  = 1'b1;
            te_d    = 1'b1;
            ti_d    = load_data[CHAIN_LEN-1];
            div_d   = '0;
            bit_d   = '0;
          end
        end
        SHIFT_IN, SHIFT_OUT: begin
          if (cp_q) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
              if (bit_q == CW'(CHAIN_LEN - 1 - i)) begin
                unload_d[i] = so_in;
              end
            end
            div_d = '0;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
              te_d  = 1'b0;
              ti_d  = 1'b0;
              if (state_q == SHIFT_IN && cap_q) begin
                state_d = CAPTURE;
              end else begin
                state_d = FINISH;
              end
            end else begin
              bit_d = bit_q + CW'(1);
              ti_d  = (state_q == SHIFT_IN) ? ld_q[CHAIN_LEN-1] : 1'b0;
              ld_d  = ld_q << 1;
            end
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        CAPTURE: begin
          if (cp_q) begin
            state_d = SHIFT_OUT;
            te_d    = 1'b1;
            ti_d    = 1'b0;
            div_d   = '0;
            bit_d   = '0;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        FINISH: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          te_d    = 1'b0;
          ti_d    = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if ((state_d == SHIFT_IN || state_d == CAPTURE || state_d == SHIFT_OUT) &&
        (div_d == DIV_LAST)) begin
      cp_d = 1'b1;
    end
  end

  // State and output registers; sd_n is held low while reset is sampled high.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      ld_q     <= '0;
      cap_q    <= 1'b0;
      cp_q     <= 1'b0;
      te_q     <= 1'b0;
      ti_q     <= 1'b0;
      sd_n_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      unload_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      ld_q     <= ld_d;
      cap_q    <= cap_d;
      cp_q     <= cp_d;
      te_q     <= te_d;
      ti_q     <= ti_d;
      sd_n_q   <= 1'b1;
      busy_q   <= busy_d;
      done_q   <= done_d;
      unload_q <= unload_d;
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Testbench for scan_chain_ctrl: a scan chain model plus a transaction-level
// reference that predicts pulse timing, te/ti, busy, done and unload_data.
module tb_scan_chain_ctrl;

  localparam int N   = 8;
  localparam int DIV = 2;

  logic         sys_clk = 1'b0;
  logic         reset;
  logic         start;
  logic         capture;
  logic         abort;
  logic [N-1:0] load_data;
  logic         so_in;
  logic         cp_out, te_out, ti_out, sd_n_out, busy, done;
  logic [N-1:0] unload_data;

  logic [N-1:0] chain  = '0;
  logic [N-1:0] chainD = '0;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit           modelReady = 0;
  bit           mActive = 0;
  int           mRel = 0;
  int           mP = 0;
  logic         mCap = 1'b0;
  logic [N-1:0] mLoad = '0;
  logic [N-1:0] mFinal = '0;
  bit           unloadValid = 0;
  logic [N-1:0] expUnload = '0;
  logic         expCp = 1'b0, expTe = 1'b0, expTi = 1'b0;
  logic         expBusy = 1'b0, expDone = 1'b0, expSd = 1'b0;
  bit           shiftWin = 0;

  scan_chain_ctrl #(.CHAIN_LEN(N), .DIV(DIV)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .start      (start),
    .capture    (capture),
    .abort      (abort),
    .load_data  (load_data),
    .so_in      (so_in),
    .cp_out     (cp_out),
    .te_out     (te_out),
    .ti_out     (ti_out),
    .sd_n_out   (sd_n_out),
    .busy       (busy),
    .done       (done),
    .unload_data(unload_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Scan chain: each flop loads its own d when te is low, otherwise shifts.
  assign so_in = chain[N-1];
  always @(posedge sys_clk) begin
    if (!sd_n_out) chain <= '1;
    else if (cp_out) chain <= te_out ? {chain[N-2:0], ti_out} : chainD;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a sequence is P pulses spaced DIV cycles apart,
  // pulse k lands in relative cycle k*DIV+DIV-1, done follows P*DIV+1 cycles on.
  initial begin
    forever begin
      @(posedge sys_clk);
      modelReady = 1;
      expDone = 1'b0;
      if (reset) begin
        mActive = 0;
        expSd = 1'b0;
        expUnload = '0;
        unloadValid = 1;
      end else begin
        expSd = 1'b1;
        if (abort) begin
          mActive = 0;
        end else if (mActive) begin
          if (mRel == mP * DIV) begin
            mActive = 0;
            expDone = 1'b1;
            expUnload = mFinal;
            unloadValid = 1;
          end else begin
            mRel++;
          end
        end else if (start) begin
          mActive = 1;
          mRel = 0;
          mCap = capture;
          mLoad = load_data;
          mP = capture ? 2 * N + 1 : N;
          mFinal = capture ? chainD : chain;
          unloadValid = 0;
        end
      end
      expBusy = mActive;
      shiftWin = mActive && (mRel < mP * DIV);
      expCp = 1'b0;
      expTe = 1'b0;
      expTi = 1'b0;
      if (shiftWin) begin
        expCp = ((mRel % DIV) == DIV - 1);
        expTe = !(mCap && (mRel / DIV) == N);
        expTi = ((mRel / DIV) < N) ? mLoad[N - 1 - (mRel / DIV)] : 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (modelReady) begin
        checkOutput("cp_out", cp_out, expCp);
        checkOutput("busy", busy, expBusy);
        checkOutput("done", done, expDone);
        checkOutput("sd_n_out", sd_n_out, expSd);
        if (shiftWin || !expBusy) begin
          checkOutput("te_out", te_out, expTe);
          checkOutput("ti_out", ti_out, expTi);
        end
        if (unloadValid && !expBusy) checkOutput("unload_data", unload_data, expUnload);
      end
    end
  end

  // One start request; optional stray starts, abort or reset at given
  // relative cycles. Returns done latency (-1 if none) and pulse count.
  task automatic applyStimulus(input logic [N-1:0] ld, input logic cap,
                               input int strayA, input int strayB,
                               input int abortAt, input int resetAt,
                               output int lat, output int pulses);
    int rel;
    @(negedge sys_clk);
    load_data = ld;
    capture = cap;
    start = 1'b1;
    @(negedge sys_clk);
    load_data = N'($urandom);
    capture = 1'b0;
    rel = 0;
    lat = -1;
    pulses = 0;
    while (rel < 80) begin
      if (cp_out === 1'b1) pulses++;
      if (done === 1'b1) begin
        lat = rel;
        break;
      end
      start = (rel == strayA || rel == strayB);
      abort = (rel == abortAt);
      reset = (rel == resetAt);
      @(negedge sys_clk);
      rel++;
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] ld;
    logic         cap;
    int           lat, pul, ab, sa, sb;

    reset = 1'b1;
    start = 1'b0;
    capture = 1'b0;
    abort = 1'b0;
    load_data = '0;
    repeat (4) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    checkOutput("chain_after_reset", chain, 8'hFF);

    // Plain load/unload
    applyStimulus(8'hA5, 1'b0, -1, -1, -1, -1, lat, pul);
    checkOutput("s1_latency", lat, 17);
    checkOutput("s1_pulses", pul, 8);
    checkOutput("s1_unload", unload_data, 8'hFF);
    checkOutput("s1_chain", chain, 8'hA5);

    // Capture sequence
    chainD = 8'h3C;
    applyStimulus(8'h00, 1'b1, -1, -1, -1, -1, lat, pul);
    checkOutput("s2_latency", lat, 35);
    checkOutput("s2_pulses", pul, 17);
    checkOutput("s2_unload", unload_data, 8'h3C);
    checkOutput("s2_chain", chain, 8'h00);

    // Back-to-back
    applyStimulus(8'h5A, 1'b0, -1, -1, -1, -1, lat, pul);
    applyStimulus(8'hC3, 1'b0, -1, -1, -1, -1, lat, pul);
    checkOutput("s3_unload", unload_data, 8'h5A);
    checkOutput("s3_latency", lat, 17);

    // Abort after the third pulse, then a normal run
    applyStimulus(8'h77, 1'b0, -1, -1, 6, -1, lat, pul);
    checkOutput("s4_abort_nodone", lat, 32'hFFFF_FFFF);
    checkOutput("s4_abort_pulses", pul, 3);
    applyStimulus(8'h0F, 1'b0, -1, -1, -1, -1, lat, pul);
    checkOutput("s4_latency", lat, 17);
    checkOutput("s4_chain", chain, 8'h0F);

    // Starts during SHIFT_IN and FINISH are ignored
    applyStimulus(8'h81, 1'b0, 4, 16, -1, -1, lat, pul);
    checkOutput("s5_latency", lat, 17);
    checkOutput("s5_pulses", pul, 8);
    @(negedge sys_clk);
    checkOutput("s5_idle_after", busy, 1'b0);

    // Reset during CAPTURE
    applyStimulus(8'hE7, 1'b1, -1, -1, -1, 16, lat, pul);
    checkOutput("s6_nodone", lat, 32'hFFFF_FFFF);
    checkOutput("s6_chain", chain, 8'hFF);
    checkOutput("s6_unload", unload_data, 8'h00);
    applyStimulus(8'h96, 1'b0, -1, -1, -1, -1, lat, pul);
    checkOutput("s6_latency", lat, 17);
    checkOutput("s6_unload_after", unload_data, 8'hFF);

    // Randomized sequences checked by the model
    for (int r = 0; r < 25; r++) begin
      chainD = N'($urandom);
      ld = N'($urandom);
      cap = 1'($urandom_range(0, 1));
      ab = -1;
      sa = -1;
      sb = -1;
      case ($urandom_range(0, 3))
        0: ab = int'($urandom_range(0, 40));
        1: begin
          sa = int'($urandom_range(0, 15));
          sb = cap ? 34 : 16;
        end
        default: ;
      endcase
      applyStimulus(ld, cap, sa, sb, ab, -1, lat, pul);
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    end

    repeat (3) @(negedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
